thor2024_icache_line_fill: RTL and testbench

Instruction-cache line-fill engine sitting directly upstream of the 512-entry × 512-bit I-cache line SRAM. On an I-cache miss it issues one burst request to the memory bus and collects four 128-bit beats in critical-beat-first wrap order. It assembles them into a 512-bit ICacheLine and writes the line into the SRAM write port in a single cycle. It reports completion or bus error to the fetch stage.

---
 rtl/thor2024_icache_line_fill.sv | 155 +++++++++++++++
 tb/tb_thor2024_icache_line_fill.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/thor2024_icache_line_fill.sv
// thor2024_icache_line_fill
// Instruction-cache line-fill engine. On a miss it issues one burst request,
// collects BEATS response beats in critical-beat-first wrap order, assembles
// them into one cache line and writes the line to the I-cache SRAM in a single
// cycle. It then reports completion, or a bus error, to the fetch stage.
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   miss_req/miss_adr fetch miss request and its byte address (sampled when idle)
//   busy              fill in progress
//   mreq/madr/mack    burst request, start address and bus acceptance
//   rvalid/rdat/rerr  response beat valid, data and error
//   wr/wadr/wdat      SRAM write strobe, line index and assembled line
//   fill_done         one-cycle end-of-fill pulse
//   fill_err          error status, valid with fill_done
// All outputs are registered.
module thor2024_icache_line_fill #(
  parameter int unsigned BEAT_WIDTH = 128,
  parameter int unsigned BEATS      = 4,
  parameter int unsigned ADR_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          miss_req,
  input  logic [ADR_WIDTH-1:0]          miss_adr,
  output logic                          busy,
  output logic                          mreq,
  output logic [ADR_WIDTH-1:0]          madr,
  input  logic                          mack,
  input  logic                          rvalid,
  input  logic [BEAT_WIDTH-1:0]         rdat,
  input  logic                          rerr,
  output logic                          wr,
  output logic [8:0]                    wadr,
  output logic [BEATS*BEAT_WIDTH-1:0]   wdat,
  output logic                          fill_done,
  output logic                          fill_err
);

  localparam int unsigned CW = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RECV  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t                 state_q;
  logic                   busy_q;
  logic                   mreq_q;
  logic [ADR_WIDTH-1:0]   madr_q;
  logic [8:0]             wadr_q;
  logic                   wr_q;
  logic                   done_q;
  logic                   ferr_q;
  logic [CW-1:0]          sb_q;
  logic [CW-1:0]          cnt_q;
  logic                   err_q;
  logic [BEAT_WIDTH-1:0]  line_q [BEATS];
  logic [CW-1:0]          slot_d;
  logic                   err_d;

  // Byte offset within a beat never affects the fill.
  logic unused_adr_lsbs;
  assign unused_adr_lsbs = ^miss_adr[3:0];

  // Wrap-order slot for the current beat: beat 0 is the critical one.
  always_comb begin
    slot_d = sb_q + cnt_q;
    err_d  = err_q | rerr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      mreq_q  <= 1'b0;
      madr_q  <= '0;
      wadr_q  <= '0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      sb_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      wr_q   <= 1'b0;
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (miss_req) begin
            state_q <= REQ;
            busy_q  <= 1'b1;
            mreq_q  <= 1'b1;
            madr_q  <= {miss_adr[ADR_WIDTH-1:4], 4'h0};
            wadr_q  <= miss_adr[14:6];
            sb_q    <= miss_adr[4 +: CW];
            cnt_q   <= '0;
            err_q   <= 1'b0;
          end
        end
        REQ: begin
          if (mack) begin
            state_q <= RECV;
            mreq_q  <= 1'b0;
          end
        end
        RECV: begin
          if (rvalid) begin
            cnt_q <= cnt_q + 1'b1;
            err_q <= err_d;
            // Last beat: the write strobe and status are registered here so
            // they appear together with the completed line in WRITE.
            if (cnt_q == CW'(BEATS - 1)) begin
              state_q <= WRITE;
              wr_q    <= ~err_d;
              done_q  <= 1'b1;
              ferr_q  <= err_d;
            end
          end
        end
        WRITE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Line buffer is not reset; its contents only matter while wr is high.
  always_ff @(posedge clk) begin
    if (state_q == RECV && rvalid) begin
      line_q[slot_d] <= rdat;
    end
  end

  always_comb begin
    wdat = '0;
    for (int unsigned k = 0; k < BEATS; k++) begin
      wdat[k*BEAT_WIDTH +: BEAT_WIDTH] = line_q[k];
    end
  end

  assign busy      = busy_q;
  assign mreq      = mreq_q;
  assign madr      = madr_q;
  assign wadr      = wadr_q;
  assign wr        = wr_q;
  assign fill_done = done_q;
  assign fill_err  = ferr_q;

endmodule

// File: tb/tb_thor2024_icache_line_fill.sv
module tb_thor2024_icache_line_fill;

  logic         clk;
  logic         rst;
  logic         miss_req;
  logic [31:0]  miss_adr;
  logic         busy;
  logic         mreq;
  logic [31:0]  madr;
  logic         mack;
  logic         rvalid;
  logic [127:0] rdat;
  logic         rerr;
  logic         wr;
  logic [8:0]   wadr;
  logic [511:0] wdat;
  logic         fill_done;
  logic         fill_err;

  thor2024_icache_line_fill #(
    .BEAT_WIDTH (128),
    .BEATS      (4),
    .ADR_WIDTH  (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .miss_req  (miss_req),
    .miss_adr  (miss_adr),
    .busy      (busy),
    .mreq      (mreq),
    .madr      (madr),
    .mack      (mack),
    .rvalid    (rvalid),
    .rdat      (rdat),
    .rerr      (rerr),
    .wr        (wr),
    .wadr      (wadr),
    .wdat      (wdat),
    .fill_done (fill_done),
    .fill_err  (fill_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]   a;
    logic [511:0] d;
  } line_t;

  line_t        line_q [$];
  logic         done_q [$];
  int           total = 0;
  int           bad   = 0;
  int unsigned  steps = 0;
  logic [127:0] bt [4];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    steps++;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Scoreboard: SRAM writes and completion pulses popped as the DUT emits them.
  always @(negedge clk) begin
    if (wr === 1'b1) begin
      chk("wr_expected", 512'(line_q.size() > 0), 512'd1);
      if (line_q.size() > 0) begin
        line_t e;
        e = line_q.pop_front();
        chk("wadr", 512'(wadr), 512'(e.a));
        chk("wdat", wdat, e.d);
      end
    end
    if (fill_done === 1'b1) begin
      chk("done_expected", 512'(done_q.size() > 0), 512'd1);
      if (done_q.size() > 0) begin
        logic e;
        e = done_q.pop_front();
        chk("fill_err", 512'(fill_err), 512'(e));
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 512'(busy), 512'd0);
    chk({tag, "_mreq"}, 512'(mreq), 512'd0);
    chk({tag, "_wr"}, 512'(wr), 512'd0);
    chk({tag, "_done"}, 512'(fill_done), 512'd0);
    chk({tag, "_ferr"}, 512'(fill_err), 512'd0);
    chk({tag, "_madr"}, 512'(madr), 512'd0);
    chk({tag, "_wadr"}, 512'(wadr), 512'd0);
  endtask

  // One complete fill. Beats bt[0..3] are delivered in that order.
  task automatic fill(input logic [31:0] adr, input int unsigned mack_dly, input bit gapped,
                      input logic [3:0] errs, input bit inject, input logic [511:0] exp_line);
    int unsigned t0;
    line_t       e;
    t0 = steps;
    miss_req = 1'b1;
    miss_adr = adr;
    step();
    miss_req = 1'b0;
    chk("req_busy", 512'(busy), 512'd1);
    chk("req_mreq", 512'(mreq), 512'd1);
    chk("req_madr", 512'(madr), 512'({adr[31:4], 4'h0}));
    if (errs == 4'd0) begin
      e.a = adr[14:6];
      e.d = exp_line;
      line_q.push_back(e);
    end
    done_q.push_back(|errs);
    for (int unsigned c = 0; c < mack_dly; c++) begin
      // stray beats before acceptance must be dropped
      rvalid = 1'b1;
      rdat   = rnd128();
      step();
      rvalid = 1'b0;
      chk("hold_mreq", 512'(mreq), 512'd1);
      chk("hold_busy", 512'(busy), 512'd1);
    end
    mack = 1'b1;
    if (mack_dly > 0) begin
      rvalid = 1'b1;
      rdat   = rnd128();
    end
    step();
    mack   = 1'b0;
    rvalid = 1'b0;
    chk("ack_mreq", 512'(mreq), 512'd0);
    for (int unsigned i = 0; i < 4; i++) begin
      if (gapped) begin
        for (int unsigned g = 0; g < i; g++) begin
          step();
          chk("gap_busy", 512'(busy), 512'd1);
          chk("gap_wr", 512'(wr), 512'd0);
        end
      end
      rvalid = 1'b1;
      rdat   = bt[i];
      rerr   = errs[i];
      if (inject && i == 2) begin
        miss_req = 1'b1;
        miss_adr = 32'h0000_2000;
      end
      step();
      rvalid   = 1'b0;
      rerr     = 1'b0;
      miss_req = 1'b0;
      miss_adr = adr;
      if (i < 3) begin
        chk("beat_busy", 512'(busy), 512'd1);
        chk("beat_done", 512'(fill_done), 512'd0);
        chk("beat_madr", 512'(madr), 512'({adr[31:4], 4'h0}));
      end else begin
        chk("end_done", 512'(fill_done), 512'd1);
        chk("end_ferr", 512'(fill_err), 512'(|errs));
        chk("end_wr", 512'(wr), 512'(errs == 4'd0));
        chk("end_busy", 512'(busy), 512'd1);
      end
    end
    if (mack_dly == 0 && !gapped) chk("latency", 512'(steps - t0), 512'd6);
    step();
    chk("post_busy", 512'(busy), 512'd0);
    chk("post_wr", 512'(wr), 512'd0);
    chk("post_done", 512'(fill_done), 512'd0);
  endtask

  initial begin
    rst      = 1'b1;
    miss_req = 1'b0;
    miss_adr = '0;
    mack     = 1'b0;
    rvalid   = 1'b0;
    rdat     = '0;
    rerr     = 1'b0;
    repeat (2) step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    // aligned fill, back-to-back beats
    for (int i = 0; i < 4; i++) bt[i] = rnd128();
    fill(32'h0000_1000, 0, 1'b0, 4'b0000, 1'b0, {bt[3], bt[2], bt[1], bt[0]});

    // critical beat in slot 3: slots 3..0 hold A, D, C, B
    for (int i = 0; i < 4; i++) bt[i] = rnd128();
    fill(32'h0000_7FF4, 0, 1'b0, 4'b0000, 1'b0, {bt[0], bt[3], bt[2], bt[1]});

    // late mack and gapped beats, same line layout as the aligned case
    for (int i = 0; i < 4; i++) bt[i] = rnd128();
    fill(32'h0000_1000, 5, 1'b1, 4'b0000, 1'b0, {bt[3], bt[2], bt[1], bt[0]});

    // bus error on the second beat
    for (int i = 0; i < 4; i++) bt[i] = rnd128();
    fill(32'h0000_2350, 0, 1'b0, 4'b0010, 1'b0, '0);

    // miss_req while busy is dropped
    for (int i = 0; i < 4; i++) bt[i] = rnd128();
    fill(32'h0000_3000, 0, 1'b0, 4'b0000, 1'b1, {bt[3], bt[2], bt[1], bt[0]});
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_second_mreq", 512'(mreq), 512'd0);
      chk("no_second_busy", 512'(busy), 512'd0);
    end

    // reset after two beats, then the rest of the burst drains in idle
    miss_req = 1'b1;
    miss_adr = 32'h0000_5060;
    step();
    miss_req = 1'b0;
    mack     = 1'b1;
    step();
    mack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rvalid = 1'b1;
      rdat   = rnd128();
      step();
    end
    rvalid = 1'b0;
    rst    = 1'b1;
    step();
    rst = 1'b0;
    chk_all_zero("midrst");
    for (int i = 0; i < 2; i++) begin
      rvalid = 1'b1;
      rdat   = rnd128();
      step();
      rvalid = 1'b0;
      chk("drain_busy", 512'(busy), 512'd0);
      chk("drain_mreq", 512'(mreq), 512'd0);
    end
    step();
    // clean refill, sb=2: slots 3..0 hold beats 1, 0, 3, 2
    for (int i = 0; i < 4; i++) bt[i] = rnd128();
    fill(32'h0000_5060, 0, 1'b0, 4'b0000, 1'b0, {bt[1], bt[0], bt[3], bt[2]});

    repeat (3) step();
    chk("lines_left", 512'(line_q.size()), 512'd0);
    chk("dones_left", 512'(done_q.size()), 512'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
